// File: rtl/accum_pkg.sv
// Shared constants for the accumulator Avalon-MM slave: register map,
// STATUS/CTRL bit positions and the bus FSM state type.
package accum_pkg;

  localparam logic [1:0] ADDR_ACC    = 2'd0;
  localparam logic [1:0] ADDR_ADD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STATUS_OVF_BIT    = 0;
  localparam int STATUS_DROP_BIT   = 1;
  localparam int STATUS_ADDCNT_LSB = 8;

  localparam int CTRL_KEYEN_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stable-sample counter that
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples,
// and a one-cycle pulse on each accepted press (falling edge of the _n level).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the raw pin into the clock domain; idle (released) level is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short bounces never get through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_avl_slave.sv
// Accumulator peripheral on an Avalon-MM slave port with two debounced keys.
// Reads take one stall cycle; writes complete in IDLE with no wait states.
// Optional feature: define ACCUM_OVF_IRQ_EN to enable the registered overflow
// interrupt and the CTRL.IRQEN bit; otherwise irq is 0 and IRQEN reads 0.
module accum_avl_slave #(
  parameter int ACC_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic [7:0]  sw,
  input  logic        key_add_n,
  input  logic        key_clr_n,
  output logic [7:0]  led,
  output logic        irq
);

  import accum_pkg::*;

  bus_state_t       state, state_next;
  logic             wait_c, rd_latch, bus_wr;
  logic [31:0]      rd_mux, rd_data;
  logic [ACC_W-1:0] acc, acc_next, operand, wd;
  logic [ACC_W:0]   sum;
  logic             do_add, ovf_set, drop_set;
  logic             ovf, drop, keyen, irqen;
  logic [7:0]       addcnt;
  logic             add_press, clr_press, add_ev, clr_ev;
  logic             status_wr, ctrl_wr;
  logic             wd_unused;

  assign wd        = avs_writedata[ACC_W-1:0];
  assign wd_unused = ^avs_writedata;
  assign status_wr = bus_wr && (avs_address == ADDR_STATUS);
  assign ctrl_wr   = bus_wr && (avs_address == ADDR_CTRL);
  assign add_ev    = add_press & keyen;
  assign clr_ev    = clr_press & keyen;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_add (
    .clk   (clk),
    .reset (reset),
    .key_n (key_add_n),
    .press (add_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk   (clk),
    .reset (reset),
    .key_n (key_clr_n),
    .press (clr_press)
  );

  // Bus FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus FSM next state and strobes: a read stalls once in IDLE and completes
  // in RD_RESP; a lone write in RD_RESP is held off one cycle.
  always_comb begin
    state_next = state;
    wait_c     = 1'b0;
    rd_latch   = 1'b0;
    bus_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (avs_read) begin
          wait_c     = 1'b1;
          rd_latch   = 1'b1;
          state_next = RD_RESP;
        end else if (avs_write) begin
          bus_wr = 1'b1;
        end
      end
      RD_RESP: begin
        state_next = IDLE;
        wait_c     = avs_write & ~avs_read;
      end
      default: state_next = IDLE;
    endcase
  end

  assign avs_waitrequest = wait_c & ~reset;

  // Register read multiplexer; unused bits and the ADD address read as 0.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_ACC: rd_mux[ACC_W-1:0] = acc;
      ADDR_STATUS: begin
        rd_mux[STATUS_OVF_BIT]             = ovf;
        rd_mux[STATUS_DROP_BIT]            = drop;
        rd_mux[STATUS_ADDCNT_LSB +: 8]     = addcnt;
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_KEYEN_BIT] = keyen;
        rd_mux[CTRL_IRQEN_BIT] = irqen;
      end
      default: rd_mux = '0;
    endcase
  end

  // Capture the selected register when a read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rd_data <= '0;
    else if (rd_latch) rd_data <= rd_mux;
  end

  assign avs_readdata = rd_data;

  // Accumulator update with priority bus write > key_clr > key_add; any key
  // event that loses to a higher-priority source is reported as a drop.
  always_comb begin
    acc_next = acc;
    operand  = '0;
    do_add   = 1'b0;
    drop_set = 1'b0;
    ovf_set  = 1'b0;
    if (bus_wr && (avs_address == ADDR_ACC)) begin
      acc_next = wd;
      drop_set = add_ev | clr_ev;
    end else if (bus_wr && (avs_address == ADDR_ADD)) begin
      do_add   = 1'b1;
      operand  = wd;
      drop_set = add_ev | clr_ev;
    end else if (clr_ev) begin
      acc_next = '0;
      drop_set = add_ev;
    end else if (add_ev) begin
      do_add  = 1'b1;
      operand = ACC_W'(sw);
    end
    sum = {1'b0, acc} + {1'b0, operand};
    if (do_add) begin
      acc_next = sum[ACC_W-1:0];
      ovf_set  = sum[ACC_W];
    end
  end

  // Accumulator, sticky status bits (set beats W1C clear), add counter, KEYEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      ovf    <= 1'b0;
      drop   <= 1'b0;
      addcnt <= '0;
      keyen  <= 1'b1;
    end else begin
      acc  <= acc_next;
      ovf  <= (ovf  & ~(status_wr & avs_writedata[STATUS_OVF_BIT]))  | ovf_set;
      drop <= (drop & ~(status_wr & avs_writedata[STATUS_DROP_BIT])) | drop_set;
      if (do_add)  addcnt <= addcnt + 8'd1;
      if (ctrl_wr) keyen  <= avs_writedata[CTRL_KEYEN_BIT];
    end
  end

`ifdef ACCUM_OVF_IRQ_EN
  // IRQEN register and registered overflow interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ctrl_wr) irqen <= avs_writedata[CTRL_IRQEN_BIT];
      irq <= ovf & irqen;
    end
  end
`else
  assign irqen = 1'b0;
  assign irq   = 1'b0;
`endif

  assign led = acc[7:0];

endmodule

// File: tb/tb_accum_avl_slave.sv
// Self-checking bench for accum_avl_slave (DEBOUNCE_CYCLES=4). A behavioural
// model tracks the register file, read handshake and key debouncing; a
// negedge compare process checks the outputs every cycle, and directed
// sequences add literal expectations. Honours ACCUM_OVF_IRQ_EN.
module tb_accum_avl_slave;

  localparam int ACC_W = 16;
  localparam int DB    = 4;
  localparam int unsigned MASK = (1 << ACC_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  sw = '0;
  logic        key_add_n = 1'b1;
  logic        key_clr_n = 1'b1;
  logic [7:0]  led;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  accum_avl_slave #(.ACC_W(ACC_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .sw              (sw),
    .key_add_n       (key_add_n),
    .key_clr_n       (key_clr_n),
    .led             (led),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_acc, m_addcnt;
  bit          m_ovf, m_drop, m_keyen, m_irqen, m_irq, m_in_resp;
  logic [31:0] m_rdlatch;
  bit          p_add, p_clr, lvl_add, lvl_clr;
  bit          hist_add[$], hist_clr[$];

  function automatic void model_reset();
    m_acc = 0; m_addcnt = 0; m_ovf = 0; m_drop = 0;
    m_keyen = 1; m_irqen = 0; m_irq = 0; m_in_resp = 0; m_rdlatch = '0;
    p_add = 0; p_clr = 0; lvl_add = 1; lvl_clr = 1;
    hist_add.delete(); hist_clr.delete();
    for (int k = 0; k < DB + 2; k++) begin
      hist_add.push_back(1'b1);
      hist_clr.push_back(1'b1);
    end
  endfunction

  function automatic logic [31:0] regval(logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_acc);
      2'd1:    return 32'd0;
      2'd2:    return 32'((m_addcnt << 8) | (int'(m_drop) << 1) | int'(m_ovf));
      default: return 32'((int'(m_irqen) << 1) | int'(m_keyen));
    endcase
  endfunction

  // The oldest DB entries of the history are the synchronised samples seen
  // at this edge; a level is accepted once all of them agree on a new value.
  function automatic void settle(input bit q[$], inout bit lvl, output bit ev);
    bit same = 1'b1;
    for (int k = 1; k < DB; k++) if (q[k] != q[0]) same = 1'b0;
    ev = 1'b0;
    if (same && q[0] != lvl) begin
      lvl = q[0];
      ev  = !lvl;
    end
  endfunction

  function automatic void model_step();
    bit bus_wr, aev, cev, ovf_set, drop_set, do_add, ovf_pre, irqen_pre;
    int unsigned operand, sum;
    ovf_pre = m_ovf; irqen_pre = m_irqen;
    bus_wr = !m_in_resp && avs_write && !avs_read;
    if (!m_in_resp && avs_read) begin
      m_rdlatch = regval(avs_address);
      m_in_resp = 1;
    end else begin
      m_in_resp = 0;
    end
    aev = p_add && m_keyen; cev = p_clr && m_keyen;
    ovf_set = 0; drop_set = 0; do_add = 0; operand = 0;
    if (bus_wr && avs_address == 2'd0) begin
      m_acc = avs_writedata & MASK; drop_set = aev || cev;
    end else if (bus_wr && avs_address == 2'd1) begin
      do_add = 1; operand = avs_writedata & MASK; drop_set = aev || cev;
    end else if (cev) begin
      m_acc = 0; drop_set = aev;
    end else if (aev) begin
      do_add = 1; operand = sw;
    end
    if (do_add) begin
      sum = m_acc + operand;
      ovf_set = sum > MASK;
      m_acc = sum & MASK;
      m_addcnt = (m_addcnt + 1) % 256;
    end
    if (bus_wr && avs_address == 2'd2) begin
      if (avs_writedata[0]) m_ovf = 0;
      if (avs_writedata[1]) m_drop = 0;
    end
    if (ovf_set) m_ovf = 1;
    if (drop_set) m_drop = 1;
    if (bus_wr && avs_address == 2'd3) begin
      m_keyen = avs_writedata[0];
`ifdef ACCUM_OVF_IRQ_EN
      m_irqen = avs_writedata[1];
`endif
    end
`ifdef ACCUM_OVF_IRQ_EN
    m_irq = ovf_pre && irqen_pre;
`endif
    hist_add.push_back(key_add_n); hist_add.delete(0);
    hist_clr.push_back(key_clr_n); hist_clr.delete(0);
    settle(hist_add, lvl_add, p_add);
    settle(hist_clr, lvl_clr, p_clr);
  endfunction

  // Advance the model on every clock edge, and reset it with the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_wait;
    exp_wait = !reset && ((!m_in_resp && avs_read) || (m_in_resp && avs_write && !avs_read));
    check("waitrequest", 32'(avs_waitrequest), 32'(exp_wait));
    check("led", 32'(led), 32'(m_acc & 8'hFF));
    check("irq", 32'(irq), 32'(m_irq));
    if (m_in_resp) check("readdata", avs_readdata, m_rdlatch);
    if (reset)     check("readdata_rst", avs_readdata, 32'd0);
  end

  // ---------------- stimulus ----------------
  bit rand_keys = 0;
  int hold_add = 0, hold_clr = 0;

  task automatic cyc();
    @(posedge clk); #1;
    if (rand_keys) begin
      if (hold_add == 0) begin key_add_n = ~key_add_n; hold_add = $urandom_range(1, 12); end
      else hold_add--;
      if (hold_clr == 0) begin key_clr_n = ~key_clr_n; hold_clr = $urandom_range(4, 40); end
      else hold_clr--;
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
    end
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(logic [1:0] a, output logic [31:0] d, output int waits);
    avs_address = a; avs_read = 1'b1; waits = 0; d = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (avs_waitrequest) waits++;
      d = avs_readdata;
      cyc();
    end
    avs_read = 1'b0;
  endtask

  task automatic applyStimulus();
    int unsigned r, d;
    r = $urandom_range(0, 9);
    d = $urandom;
    if (r < 3) begin
      cyc();
    end else if (r < 5) begin
      logic [31:0] rd; int w;
      bus_read(2'($urandom), rd, w);
    end else if (r < 8) begin
      if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
      bus_write(2'($urandom), d);
    end else if (r == 8) begin
      avs_address = 2'($urandom); avs_writedata = d;
      avs_read = 1'b1; avs_write = 1'b1;
      cyc(); cyc();
      avs_read = 1'b0; avs_write = 1'b0;
    end else begin
      avs_address = 2'd0; avs_read = 1'b1;
      cyc();
      avs_read = 1'b0; avs_write = 1'b1;
      avs_address = 2'($urandom_range(0, 2)); avs_writedata = d;
      cyc(); cyc();
      avs_write = 1'b0;
    end
  endtask

  task automatic checkOutput(string name, logic [1:0] a, logic [31:0] exp);
    logic [31:0] rd; int w;
    bus_read(a, rd, w);
    check({name, "_data"}, rd, exp);
    check({name, "_stall"}, 32'(w), 32'd1);
  endtask

  initial begin
    logic [31:0] rd; int w;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) cyc();
    checkOutput("ctrl_rst", 2'd3, 32'h1);
    checkOutput("status_rst", 2'd2, 32'h0);

    // Load then read back the accumulator.
    bus_write(2'd0, 32'h00F0);
    checkOutput("acc_f0", 2'd0, 32'h00F0);
    @(negedge clk);
    check("led_f0", 32'(led), 32'hF0);
    cyc();

    // Wrapping add sets OVF; W1C clears it.
    bus_write(2'd0, 32'h0000_FFFF);
    bus_write(2'd1, 32'h0000_0002);
    checkOutput("acc_wrap", 2'd0, 32'h0001);
    checkOutput("status_ovf", 2'd2, 32'h0101);
    bus_write(2'd2, 32'h1);
    checkOutput("status_w1c", 2'd2, 32'h0100);
    checkOutput("add_reads0", 2'd1, 32'h0);

    // Bouncing key then a long hold: exactly one add of sw.
    sw = 8'h05;
    for (int i = 0; i < 3; i++) begin
      key_add_n = 1'b0; cyc();
      key_add_n = 1'b1; cyc();
    end
    key_add_n = 1'b0; repeat (20) cyc();
    key_add_n = 1'b1; repeat (12) cyc();
    checkOutput("acc_key_add", 2'd0, 32'h0006);
    checkOutput("status_key_add", 2'd2, 32'h0200);

    // Key event lands on the same edge as a bus write to ACC.
    key_add_n = 1'b0;
    repeat (6) cyc();
    bus_write(2'd0, 32'h0010);
    repeat (10) cyc();
    key_add_n = 1'b1; repeat (12) cyc();
    checkOutput("acc_drop", 2'd0, 32'h0010);
    checkOutput("status_drop", 2'd2, 32'h0202);
    bus_write(2'd2, 32'h2);

    // Clear key zeroes the accumulator.
    key_clr_n = 1'b0; repeat (10) cyc();
    key_clr_n = 1'b1; repeat (10) cyc();
    checkOutput("acc_key_clr", 2'd0, 32'h0);

    // Overflow interrupt path.
    bus_write(2'd3, 32'h3);
`ifdef ACCUM_OVF_IRQ_EN
    checkOutput("ctrl_irqen", 2'd3, 32'h3);
`else
    checkOutput("ctrl_irqen", 2'd3, 32'h1);
`endif
    bus_write(2'd0, 32'hFFFF);
    bus_write(2'd1, 32'h1);
    @(negedge clk);
    check("irq_lag", 32'(irq), 32'd0);
    cyc();
    @(negedge clk);
`ifdef ACCUM_OVF_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
`else
    check("irq_set", 32'(irq), 32'd0);
`endif
    cyc();
    bus_write(2'd2, 32'h1);
    cyc();
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);
    cyc();

    // Reset during RD_RESP aborts the read.
    bus_write(2'd0, 32'h1234);
    avs_address = 2'd0; avs_read = 1'b1;
    cyc();
    reset = 1'b1; avs_read = 1'b0;
    @(negedge clk);
    check("rst_midread_wait", 32'(avs_waitrequest), 32'd0);
    cyc();
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_wait", 32'(avs_waitrequest), 32'd0);
    check("post_rst_led", 32'(led), 32'd0);
    checkOutput("post_rst_acc", 2'd0, 32'h0);

    // Randomised traffic on bus and keys, checked by the model every cycle.
    rand_keys = 1;
    for (int n = 0; n < 1500; n++) applyStimulus();
    rand_keys = 0;
    key_add_n = 1'b1; key_clr_n = 1'b1;
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
